// File: rtl/rv_pkg.sv
// Shared RV32I core constants: register file geometry and the x0 index.
package rv_pkg;

    localparam int          XLEN       = 32;
    localparam int          REG_ADDR_W = 5;
    localparam int          NUM_REGS   = 32;
    localparam logic [4:0]  REG_ZERO   = 5'd0;

endpackage

// File: rtl/register_file_if.sv
// Register file access bus: one write port and two combinational read ports.
// The master (core datapath) drives indices and write data; the slave (register
// file) returns the read operands.
interface register_file_if
    import rv_pkg::*;
#(
    parameter int WIDTH  = XLEN,
    parameter int ADDR_W = REG_ADDR_W
);

    logic              we;
    logic [ADDR_W-1:0] rd;
    logic [WIDTH-1:0]  wd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;

    modport master (
        output we, rd, wd, rs1, rs2,
        input  rd1, rd2
    );

    modport slave (
        input  we, rd, wd, rs1, rs2,
        output rd1, rd2
    );

endinterface

// File: rtl/reg_wr_decoder.sv
// Write-side decoder: turns rd + we into a one-hot register write enable.
// Bit 0 is never set, so writes to x0 are silently discarded.
module reg_wr_decoder #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              we_i,
    input  logic [ADDR_W-1:0] rd_i,
    output logic [DEPTH-1:0]  wen_o
);

    // One-hot decode of the destination index, x0 excluded.
    always_comb begin
        wen_o = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (we_i && (rd_i == ADDR_W'(i))) begin
                wen_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// RV32I integer register file: two asynchronous read ports, one synchronous
// write port, x0 hardwired to zero (not stored).
// Optional build macro REGFILE_BYPASS_EN: when defined, a write in progress is
// forwarded to a read port addressing the same register in the same cycle
// (suppressed while rst_n is low). When undefined, same-cycle reads return the
// old register contents.
module register_file
    import rv_pkg::*;
#(
    parameter int WIDTH  = XLEN,
    parameter int DEPTH  = NUM_REGS,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    register_file_if.slave  bus
);

    logic [DEPTH-1:0] wen;
    logic             wen_unused;
    logic [WIDTH-1:0] regs_q [DEPTH-1:1];
    logic [WIDTH-1:0] regs_d [DEPTH-1:1];
    logic [WIDTH-1:0] rdata1;
    logic [WIDTH-1:0] rdata2;

    reg_wr_decoder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_wr_dec (
        .we_i   (bus.we),
        .rd_i   (bus.rd),
        .wen_o  (wen)
    );

    // x0 has no storage; its enable bit is always zero by construction.
    assign wen_unused = wen[0];

    // Next-state: reset clears everything and wins over a concurrent write.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < DEPTH; i++) begin
            if (!rst_n) begin
                regs_d[i] = '0;
            end else if (wen[i]) begin
                regs_d[i] = bus.wd;
            end
        end
    end

    // Register storage for x1..x(DEPTH-1).
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Read selects with x0 returning constant zero, plus optional write-through.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (bus.rs1 == ADDR_W'(i)) begin
                rdata1 = regs_q[i];
            end
            if (bus.rs2 == ADDR_W'(i)) begin
                rdata2 = regs_q[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (rst_n && bus.we && (bus.rd != ADDR_W'(REG_ZERO))) begin
            if (bus.rs1 == bus.rd) begin
                rdata1 = bus.wd;
            end
            if (bus.rs2 == bus.rd) begin
                rdata2 = bus.wd;
            end
        end
`endif
    end

    assign bus.rd1 = rdata1;
    assign bus.rd2 = rdata2;

endmodule
